// File: rtl/osd_reg_initiator_if.sv
// DII flit type plus the controller-side command/completion interface
// used by the register-access initiator.
package dii_pkg;
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;
endpackage

interface osd_reg_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_dest;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [15:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_dest, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_dest, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/osd_reg_initiator.sv
// Register-access initiator: turns one controller command into a REG request
// packet on debug_out and completes it from the matching REG response.
module osd_reg_initiator
  import dii_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_PKT_LEN    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         id,
  osd_reg_initiator_if.slave ctrl,
  output dii_flit            debug_out,
  input  logic               debug_out_ready,
  input  dii_flit            debug_in,
  output logic               debug_in_ready
);

  localparam logic [3:0] SUB_READ   = 4'h0;
  localparam logic [3:0] SUB_WRITE  = 4'h4;
  localparam logic [3:0] SUB_RD_OK  = 4'h8;
  localparam logic [3:0] SUB_RD_ERR = 4'hC;
  localparam logic [3:0] SUB_WR_OK  = 4'hD;
  localparam logic [3:0] SUB_WR_ERR = 4'hE;
  localparam bit         TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    IDLE, TX_DEST, TX_SRC, TX_FLAGS, TX_ADDR, TX_WDATA, WAIT_RESP
  } state_t;

  state_t      state;
  logic        op_write;
  logic [15:0] op_addr;
  logic [15:0] op_wdata;
  logic [31:0] wait_cnt;

  logic [7:0]  rx_idx;
  logic        rx_ovf;
  logic [15:0] rx_dest;
  logic [15:0] rx_flags;
  logic [15:0] rx_payload;

  logic [15:0] dest_cur;
  logic [15:0] flags_cur;
  logic [15:0] payload_cur;
  logic [3:0]  rx_sub;
  logic [7:0]  rx_len;
  logic        sub_ok;
  logic        len_ok;
  logic        rx_match;
  logic        timeout_hit;

  assign debug_in_ready = 1'b1;

  // Fields of the flit arriving this cycle are bypassed so the final flit can be judged immediately.
  assign dest_cur    = (rx_idx == 8'd0) ? debug_in.data : rx_dest;
  assign flags_cur   = (rx_idx == 8'd2) ? debug_in.data : rx_flags;
  assign payload_cur = (rx_idx == 8'd3) ? debug_in.data : rx_payload;
  assign rx_sub      = flags_cur[13:10];
  assign rx_len      = rx_idx + 8'd1;
  assign sub_ok      = op_write ? (rx_sub == SUB_WR_OK || rx_sub == SUB_WR_ERR)
                                : (rx_sub == SUB_RD_OK || rx_sub == SUB_RD_ERR);
  assign len_ok      = (rx_sub == SUB_RD_OK) ? (rx_len == 8'd4) : (rx_len == 8'd3);
  assign rx_match    = debug_in.valid && debug_in.last && !rx_ovf &&
                       (state == WAIT_RESP) && (dest_cur == 16'(id)) &&
                       (flags_cur[15:14] == 2'b00) && sub_ok && len_ok;
  assign timeout_hit = TIMEOUT_EN && (state == WAIT_RESP) &&
                       (wait_cnt == 32'(TIMEOUT_CYCLES - 1));

  // Incoming packet tracker; an over-length packet is flagged and discarded at its last flit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_idx     <= 8'd0;
      rx_ovf     <= 1'b0;
      rx_dest    <= 16'h0;
      rx_flags   <= 16'h0;
      rx_payload <= 16'h0;
    end else if (debug_in.valid) begin
      if (rx_idx == 8'd0) rx_dest    <= debug_in.data;
      if (rx_idx == 8'd2) rx_flags   <= debug_in.data;
      if (rx_idx == 8'd3) rx_payload <= debug_in.data;
      if (debug_in.last) begin
        rx_idx <= 8'd0;
        rx_ovf <= 1'b0;
      end else if (rx_idx == 8'(MAX_PKT_LEN - 1)) begin
        rx_ovf <= 1'b1;
      end else begin
        rx_idx <= rx_idx + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      op_write        <= 1'b0;
      op_addr         <= 16'h0;
      op_wdata        <= 16'h0;
      wait_cnt        <= 32'd0;
      ctrl.req_ready  <= 1'b1;
      ctrl.resp_valid <= 1'b0;
      ctrl.resp_err   <= 1'b0;
      ctrl.resp_rdata <= 16'h0;
      debug_out       <= '0;
    end else begin
      ctrl.resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ctrl.req_valid && ctrl.req_ready) begin
            op_write       <= ctrl.req_write;
            op_addr        <= ctrl.req_addr;
            op_wdata       <= ctrl.req_wdata;
            ctrl.req_ready <= 1'b0;
            debug_out      <= '{valid: 1'b1, last: 1'b0, data: ctrl.req_dest};
            state          <= TX_DEST;
          end
        end
        TX_DEST: if (debug_out_ready) begin
          debug_out.data <= 16'(id);
          state          <= TX_SRC;
        end
        TX_SRC: if (debug_out_ready) begin
          debug_out.data <= {2'b00, (op_write ? SUB_WRITE : SUB_READ), 10'h0};
          state          <= TX_FLAGS;
        end
        TX_FLAGS: if (debug_out_ready) begin
          debug_out.data <= op_addr;
          debug_out.last <= !op_write;
          state          <= TX_ADDR;
        end
        TX_ADDR: if (debug_out_ready) begin
          if (op_write) begin
            debug_out.data <= op_wdata;
            debug_out.last <= 1'b1;
            state          <= TX_WDATA;
          end else begin
            debug_out <= '0;
            wait_cnt  <= 32'd0;
            state     <= WAIT_RESP;
          end
        end
        TX_WDATA: if (debug_out_ready) begin
          debug_out <= '0;
          wait_cnt  <= 32'd0;
          state     <= WAIT_RESP;
        end
        WAIT_RESP: begin
          // A matching response takes priority over expiry in the same cycle.
          if (rx_match) begin
            ctrl.resp_valid <= 1'b1;
            ctrl.resp_err   <= (rx_sub == SUB_RD_ERR) || (rx_sub == SUB_WR_ERR);
            ctrl.resp_rdata <= (rx_sub == SUB_RD_OK) ? payload_cur : 16'h0;
            ctrl.req_ready  <= 1'b1;
            state           <= IDLE;
          end else if (timeout_hit) begin
            ctrl.resp_valid <= 1'b1;
            ctrl.resp_err   <= 1'b1;
            ctrl.resp_rdata <= 16'h0;
            ctrl.req_ready  <= 1'b1;
            state           <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_osd_reg_initiator.sv
// Scoreboard bench for osd_reg_initiator: expected request flits and
// completions are queued by the stimulus and checked by a negedge monitor.
module tb_osd_reg_initiator;
  import dii_pkg::*;

  typedef struct {
    logic        err;
    logic [15:0] rdata;
    int          lat;
  } resp_t;

  logic     clk;
  logic     rst;
  logic [9:0] id;
  dii_flit  debug_out;
  dii_flit  debug_in;
  logic     debug_out_ready;
  logic     debug_in_ready;
  bit       toggle_ready;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int tx_done = 0;
  int resp_cnt = 0;
  int last_acc_cyc = 0;

  logic [16:0] exp_tx[$];
  resp_t       exp_resp[$];
  logic [16:0] pk[$];

  osd_reg_initiator_if ctrl();

  osd_reg_initiator #(.TIMEOUT_CYCLES(16), .MAX_PKT_LEN(8)) dut (
    .clk(clk),
    .rst(rst),
    .id(id),
    .ctrl(ctrl),
    .debug_out(debug_out),
    .debug_out_ready(debug_out_ready),
    .debug_in(debug_in),
    .debug_in_ready(debug_in_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    debug_out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (toggle_ready) debug_out_ready = ~debug_out_ready;
      else debug_out_ready = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected flits/completions whenever the DUT presents them.
  initial begin
    logic        prev_stall;
    logic [16:0] prev_flit;
    logic        prev_resp;
    logic [16:0] f;
    resp_t       e;
    prev_stall = 1'b0;
    prev_flit  = '0;
    prev_resp  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (prev_stall)
          checkOutput("tx_stall_hold", 32'({debug_out.valid, debug_out.last, debug_out.data}),
                      32'({1'b1, prev_flit}));
        if (debug_out.valid && debug_out_ready) begin
          checkOutput("tx_expected", 32'(exp_tx.size() != 0), 32'd1);
          if (exp_tx.size() != 0) begin
            f = exp_tx.pop_front();
            checkOutput("tx_flit", 32'({debug_out.last, debug_out.data}), 32'(f));
          end
          if (debug_out.last) begin
            tx_done++;
            last_acc_cyc = cyc + 1;
          end
        end
        prev_stall = debug_out.valid && !debug_out_ready;
        prev_flit  = {debug_out.last, debug_out.data};

        if (prev_resp) checkOutput("resp_pulse", 32'(ctrl.resp_valid), 32'd0);
        if (ctrl.resp_valid) begin
          resp_cnt++;
          checkOutput("resp_expected", 32'(exp_resp.size() != 0), 32'd1);
          checkOutput("resp_req_ready", 32'(ctrl.req_ready), 32'd1);
          if (exp_resp.size() != 0) begin
            e = exp_resp.pop_front();
            checkOutput("resp_err", 32'(ctrl.resp_err), 32'(e.err));
            checkOutput("resp_rdata", 32'(ctrl.resp_rdata), 32'(e.rdata));
            if (e.lat >= 0) checkOutput("resp_latency", 32'(cyc - last_acc_cyc), 32'(e.lat));
          end
        end
        prev_resp = ctrl.resp_valid;
      end else begin
        prev_stall = 1'b0;
        prev_resp  = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input logic wr, input logic [15:0] dest,
                               input logic [15:0] addr, input logic [15:0] wdata);
    bit found;
    exp_tx.push_back({1'b0, dest});
    exp_tx.push_back({1'b0, 16'h0005});
    exp_tx.push_back({1'b0, (wr ? 16'h1000 : 16'h0000)});
    exp_tx.push_back({!wr, addr});
    if (wr) exp_tx.push_back({1'b1, wdata});
    @(posedge clk);
    #1;
    ctrl.req_valid = 1'b1;
    ctrl.req_write = wr;
    ctrl.req_dest  = dest;
    ctrl.req_addr  = addr;
    ctrl.req_wdata = wdata;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ctrl.req_ready) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("req_accept", 32'(found), 32'd1);
    @(posedge clk);
    #1;
    ctrl.req_valid = 1'b0;
    checkOutput("req_ready_drop", 32'(ctrl.req_ready), 32'd0);
  endtask

  task automatic waitTxDone(input string name);
    int  start;
    bit  found;
    start = tx_done;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (tx_done != start) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput({name, "_tx_done"}, 32'(found), 32'd1);
  endtask

  task automatic waitResp(input string name, input int limit);
    int  start;
    bit  found;
    start = resp_cnt;
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      #1;
      if (resp_cnt != start) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput({name, "_resp_seen"}, 32'(found), 32'd1);
  endtask

  task automatic sendFlits(input logic [16:0] flits[$], input bit chk_ready);
    foreach (flits[i]) begin
      @(posedge clk);
      #1;
      debug_in.valid = 1'b1;
      debug_in.last  = flits[i][16];
      debug_in.data  = flits[i][15:0];
      if (chk_ready) checkOutput("late_req_ready", 32'(ctrl.req_ready), 32'd1);
    end
    @(posedge clk);
    #1;
    debug_in = '0;
  endtask

  function automatic resp_t mk(input logic err, input logic [15:0] rdata, input int lat);
    resp_t r;
    r.err   = err;
    r.rdata = rdata;
    r.lat   = lat;
    return r;
  endfunction

  initial begin
    rst            = 1'b0;
    id             = 10'h005;
    debug_in       = '0;
    toggle_ready   = 1'b0;
    ctrl.req_valid = 1'b0;
    ctrl.req_write = 1'b0;
    ctrl.req_dest  = 16'h0;
    ctrl.req_addr  = 16'h0;
    ctrl.req_wdata = 16'h0;

    #22;
    checkOutput("rst_req_ready", 32'(ctrl.req_ready), 32'd1);
    checkOutput("rst_resp_valid", 32'(ctrl.resp_valid), 32'd0);
    checkOutput("rst_resp_err", 32'(ctrl.resp_err), 32'd0);
    checkOutput("rst_resp_rdata", 32'(ctrl.resp_rdata), 32'd0);
    checkOutput("rst_out_valid", 32'(debug_out.valid), 32'd0);
    checkOutput("rst_in_ready", 32'(debug_in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] read with read-ok16 response");
    applyStimulus(1'b0, 16'h0000, 16'h0200, 16'h0000);
    waitTxDone("read_ok");
    exp_resp.push_back(mk(1'b0, 16'hABCD, -1));
    pk = '{17'h00005, 17'h00000, 17'h02000, 17'h1ABCD};
    sendFlits(pk, 1'b0);
    waitResp("read_ok", 20);
    repeat (3) @(posedge clk);

    $display("[TB] write with stalled debug_out");
    toggle_ready = 1'b1;
    applyStimulus(1'b1, 16'h0000, 16'h0003, 16'h1234);
    waitTxDone("write_ok");
    toggle_ready = 1'b0;
    exp_resp.push_back(mk(1'b0, 16'h0000, -1));
    pk = '{17'h00005, 17'h00000, 17'h13400};
    sendFlits(pk, 1'b0);
    waitResp("write_ok", 20);
    repeat (3) @(posedge clk);

    $display("[TB] read with read-err response");
    applyStimulus(1'b0, 16'h0000, 16'h0010, 16'h0000);
    waitTxDone("read_err");
    exp_resp.push_back(mk(1'b1, 16'h0000, -1));
    pk = '{17'h00005, 17'h00000, 17'h13000};
    sendFlits(pk, 1'b0);
    waitResp("read_err", 20);
    repeat (3) @(posedge clk);

    $display("[TB] dropped packets then a valid response");
    applyStimulus(1'b0, 16'h0000, 16'h0020, 16'h0000);
    waitTxDone("drop");
    exp_resp.push_back(mk(1'b0, 16'h5A5A, -1));
    pk = '{17'h00007, 17'h00000, 17'h13000,
           17'h00005, 17'h00000, 17'h1B000,
           17'h00005, 17'h00000, 17'h02000, 17'h01111, 17'h12222,
           17'h00005, 17'h00000, 17'h02000, 17'h15A5A};
    sendFlits(pk, 1'b0);
    waitResp("drop", 20);
    repeat (3) @(posedge clk);

    $display("[TB] timeout then late response");
    applyStimulus(1'b0, 16'h0000, 16'h0030, 16'h0000);
    waitTxDone("timeout");
    exp_resp.push_back(mk(1'b1, 16'h0000, 16));
    waitResp("timeout", 40);
    pk = '{17'h00005, 17'h00000, 17'h02000, 17'h1DEAD};
    sendFlits(pk, 1'b1);
    repeat (4) @(posedge clk);

    $display("[TB] reset during request transmission");
    applyStimulus(1'b0, 16'h0000, 16'h0040, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(debug_out.valid), 32'd0);
    checkOutput("midrst_req_ready", 32'(ctrl.req_ready), 32'd1);
    checkOutput("midrst_resp_valid", 32'(ctrl.resp_valid), 32'd0);
    exp_tx.delete();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    applyStimulus(1'b0, 16'h0000, 16'h0050, 16'h0000);
    waitTxDone("post_rst");
    exp_resp.push_back(mk(1'b0, 16'hC0DE, -1));
    pk = '{17'h00005, 17'h00000, 17'h02000, 17'h1C0DE};
    sendFlits(pk, 1'b0);
    waitResp("post_rst", 20);
    repeat (5) @(posedge clk);

    checkOutput("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
    checkOutput("resp_queue_empty", 32'(exp_resp.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
